// File: rtl/conveyor_pkg.sv
// Shared conveyor definitions: parameter defaults, fault codes and the slot layout.
// Fault codes are plain integers so each module can size them to FAULT_ADDR_WIDTH.
package conveyor_pkg;

    localparam int DEF_WORD_WIDTH          = 32;
    localparam int DEF_CONVEYOR_ADDR_WIDTH = 4;
    localparam int DEF_CONTEXTS            = 4;
    localparam int DEF_WRITE_PORTS         = 2;
    localparam int DEF_FAULT_ADDR_WIDTH    = 3;

    localparam int F_NONE    = 0;
    localparam int F_BUS     = 1;
    localparam int F_ALIGN   = 2;
    localparam int F_ILLEGAL = 3;
    localparam int F_PRIV    = 4;

    typedef struct packed {
        logic                            finished;
        logic [DEF_FAULT_ADDR_WIDTH-1:0] fault;
        logic [DEF_WORD_WIDTH-1:0]       value;
    } slot_t;

    function automatic int ctx_width(input int contexts);
        return (contexts > 1) ? $clog2(contexts) : 1;
    endfunction

endpackage

// File: rtl/conveyor_ring.sv
// One conveyor context: a ring of slots that grows downward from head.
// Handles allocation, interrupt-frame push and completion writes for this context only.
module conveyor_ring
    import conveyor_pkg::*;
#(
    parameter int WORD_WIDTH          = DEF_WORD_WIDTH,
    parameter int CONVEYOR_ADDR_WIDTH = DEF_CONVEYOR_ADDR_WIDTH,
    parameter int WRITE_PORTS         = DEF_WRITE_PORTS,
    parameter int FAULT_ADDR_WIDTH    = DEF_FAULT_ADDR_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            i_alloc_en,
    input  logic                                            i_irq_en,
    input  logic [WORD_WIDTH-1:0]                           i_irq_value,
    input  logic [WORD_WIDTH-1:0]                           i_irq_bus,
    input  logic [WRITE_PORTS-1:0]                          i_wr_valid,
    input  logic [WRITE_PORTS-1:0][CONVEYOR_ADDR_WIDTH-1:0] i_wr_slot,
    input  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]          i_wr_value,
    input  logic [WRITE_PORTS-1:0][FAULT_ADDR_WIDTH-1:0]    i_wr_fault,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0]                  i_rd_offset,
    output logic [CONVEYOR_ADDR_WIDTH-1:0]                  o_rd_slot,
    output logic                                            o_rd_finished,
    output logic [FAULT_ADDR_WIDTH-1:0]                     o_rd_fault,
    output logic [WORD_WIDTH-1:0]                           o_rd_value,
    output logic [CONVEYOR_ADDR_WIDTH-1:0]                  o_head,
    output logic                                            o_alloc_ready,
    output logic                                            o_irq_ready
);

    localparam int SIZE = 1 << CONVEYOR_ADDR_WIDTH;
    localparam logic [FAULT_ADDR_WIDTH-1:0] F_NONE_W = FAULT_ADDR_WIDTH'(F_NONE);

    typedef struct packed {
        logic                        finished;
        logic [FAULT_ADDR_WIDTH-1:0] fault;
        logic [WORD_WIDTH-1:0]       value;
    } ring_slot_t;

    localparam ring_slot_t SLOT_IDLE    = '{finished: 1'b1, fault: F_NONE_W, value: {WORD_WIDTH{1'b0}}};
    localparam ring_slot_t SLOT_PENDING = '{finished: 1'b0, fault: F_NONE_W, value: {WORD_WIDTH{1'b0}}};

    ring_slot_t                     r_slots [SIZE];
    logic [CONVEYOR_ADDR_WIDTH-1:0] r_head;
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_head_m1;
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_head_m2;

    assign w_head_m1 = r_head - CONVEYOR_ADDR_WIDTH'(1);
    assign w_head_m2 = r_head - CONVEYOR_ADDR_WIDTH'(2);

    assign o_head        = r_head;
    assign o_alloc_ready = r_slots[w_head_m1].finished;
    assign o_irq_ready   = r_slots[w_head_m1].finished && r_slots[w_head_m2].finished;
    assign o_rd_slot     = r_head + i_rd_offset;
    assign o_rd_finished = r_slots[o_rd_slot].finished;
    assign o_rd_fault    = r_slots[o_rd_slot].fault;
    assign o_rd_value    = r_slots[o_rd_slot].value;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the slot array is reset explicitly because every slot must read as finished
            // right after reset; this rules out mapping it onto a RAM macro.
            for (int s = 0; s < SIZE; s++) begin
                r_slots[s] <= SLOT_IDLE;
            end
            r_head <= '0;
        end else begin
            // NOTE: with non-blocking assignments the last one to an element wins, so the ports
            // are visited highest-first and the allocation comes after all completions.
            for (int p = WRITE_PORTS - 1; p >= 0; p--) begin
                if (i_wr_valid[p] && !r_slots[i_wr_slot[p]].finished) begin
                    r_slots[i_wr_slot[p]] <= '{finished: 1'b1, fault: i_wr_fault[p], value: i_wr_value[p]};
                end
            end
            if (i_alloc_en) begin
                r_slots[w_head_m1] <= SLOT_PENDING;
                r_head             <= w_head_m1;
            end else if (i_irq_en) begin
                r_slots[w_head_m1] <= '{finished: 1'b1, fault: F_NONE_W, value: i_irq_value};
                r_slots[w_head_m2] <= '{finished: 1'b1, fault: F_NONE_W, value: i_irq_bus};
                r_head             <= w_head_m2;
            end
        end
    end

endmodule

// File: rtl/multi_conveyor_control.sv
// Multi-context conveyor: one conveyor_ring per interrupt level, with context
// selection, alloc/irq arbitration and same-cycle completion forwarding on the access path.
module multi_conveyor_control
    import conveyor_pkg::*;
#(
    parameter  int WORD_WIDTH          = DEF_WORD_WIDTH,
    parameter  int CONVEYOR_ADDR_WIDTH = DEF_CONVEYOR_ADDR_WIDTH,
    parameter  int CONTEXTS            = DEF_CONTEXTS,
    parameter  int WRITE_PORTS         = DEF_WRITE_PORTS,
    parameter  int FAULT_ADDR_WIDTH    = DEF_FAULT_ADDR_WIDTH,
    localparam int CTX_W               = ctx_width(CONTEXTS)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [CTX_W-1:0]                                ctx,
    input  logic                                            access_valid,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0]                  access_idx,
    output logic [WORD_WIDTH-1:0]                           access_value,
    output logic                                            halt,
    output logic [FAULT_ADDR_WIDTH-1:0]                     fault,
    output logic [CONVEYOR_ADDR_WIDTH-1:0]                  head,
    input  logic                                            alloc_req,
    output logic                                            alloc_grant,
    output logic [CONVEYOR_ADDR_WIDTH-1:0]                  alloc_slot,
    input  logic [WRITE_PORTS-1:0]                          wr_valid,
    input  logic [WRITE_PORTS-1:0][CTX_W-1:0]               wr_ctx,
    input  logic [WRITE_PORTS-1:0][CONVEYOR_ADDR_WIDTH-1:0] wr_slot,
    input  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]          wr_value,
    input  logic [WRITE_PORTS-1:0][FAULT_ADDR_WIDTH-1:0]    wr_fault,
    input  logic                                            irq_push,
    output logic                                            irq_ready,
    input  logic [CTX_W-1:0]                                irq_ctx,
    input  logic [CTX_W-1:0]                                irq_bus,
    input  logic [WORD_WIDTH-1:0]                           irq_value
);

    localparam logic [FAULT_ADDR_WIDTH-1:0] F_NONE_W = FAULT_ADDR_WIDTH'(F_NONE);

    logic [CONTEXTS-1:0]                          w_alloc_en;
    logic [CONTEXTS-1:0]                          w_irq_en;
    logic [CONTEXTS-1:0]                          w_alloc_ready;
    logic [CONTEXTS-1:0]                          w_irq_ready;
    logic [CONTEXTS-1:0]                          w_rd_finished;
    logic [CONTEXTS-1:0][CONVEYOR_ADDR_WIDTH-1:0] w_head;
    logic [CONTEXTS-1:0][CONVEYOR_ADDR_WIDTH-1:0] w_rd_slot;
    logic [CONTEXTS-1:0][FAULT_ADDR_WIDTH-1:0]    w_rd_fault;
    logic [CONTEXTS-1:0][WORD_WIDTH-1:0]          w_rd_value;
    logic [CONTEXTS-1:0][WRITE_PORTS-1:0]         w_wr_hit;

    logic                           w_irq_accept;
    logic                           w_sel_alloc_ready;
    logic                           w_sel_rd_finished;
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_sel_head;
    logic [CONVEYOR_ADDR_WIDTH-1:0] w_sel_rd_slot;
    logic [FAULT_ADDR_WIDTH-1:0]    w_sel_rd_fault;
    logic [WORD_WIDTH-1:0]          w_sel_rd_value;
    logic                           w_fwd_hit;
    logic [FAULT_ADDR_WIDTH-1:0]    w_fwd_fault;
    logic [WORD_WIDTH-1:0]          w_fwd_value;

    for (genvar c = 0; c < CONTEXTS; c++) begin : g_ctx
        for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_port
            assign w_wr_hit[c][p] = wr_valid[p] && (wr_ctx[p] == CTX_W'(c));
        end
        assign w_alloc_en[c] = alloc_grant && (ctx == CTX_W'(c));
        assign w_irq_en[c]   = w_irq_accept && (irq_ctx == CTX_W'(c));

        conveyor_ring #(
            .WORD_WIDTH          (WORD_WIDTH),
            .CONVEYOR_ADDR_WIDTH (CONVEYOR_ADDR_WIDTH),
            .WRITE_PORTS         (WRITE_PORTS),
            .FAULT_ADDR_WIDTH    (FAULT_ADDR_WIDTH)
        ) u_ring (
            .clk           (clk),
            .reset         (reset),
            .i_alloc_en    (w_alloc_en[c]),
            .i_irq_en      (w_irq_en[c]),
            .i_irq_value   (irq_value),
            .i_irq_bus     (WORD_WIDTH'(irq_bus)),
            .i_wr_valid    (w_wr_hit[c]),
            .i_wr_slot     (wr_slot),
            .i_wr_value    (wr_value),
            .i_wr_fault    (wr_fault),
            .i_rd_offset   (access_idx),
            .o_rd_slot     (w_rd_slot[c]),
            .o_rd_finished (w_rd_finished[c]),
            .o_rd_fault    (w_rd_fault[c]),
            .o_rd_value    (w_rd_value[c]),
            .o_head        (w_head[c]),
            .o_alloc_ready (w_alloc_ready[c]),
            .o_irq_ready   (w_irq_ready[c])
        );
    end

    // Comparing against each context index keeps out-of-range ctx values harmless.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_sel_head        = '0;
        w_sel_alloc_ready = 1'b0;
        w_sel_rd_slot     = '0;
        w_sel_rd_finished = 1'b0;
        w_sel_rd_fault    = F_NONE_W;
        w_sel_rd_value    = '0;
        irq_ready         = 1'b0;
        for (int c = 0; c < CONTEXTS; c++) begin
            if (ctx == CTX_W'(c)) begin
                w_sel_head        = w_head[c];
                w_sel_alloc_ready = w_alloc_ready[c];
                w_sel_rd_slot     = w_rd_slot[c];
                w_sel_rd_finished = w_rd_finished[c];
                w_sel_rd_fault    = w_rd_fault[c];
                w_sel_rd_value    = w_rd_value[c];
            end
            if (irq_ctx == CTX_W'(c)) begin
                irq_ready = w_irq_ready[c];
            end
        end
    end

    assign w_irq_accept = irq_push && irq_ready;
    assign alloc_grant  = alloc_req && w_sel_alloc_ready && !(w_irq_accept && (irq_ctx == ctx));
    assign alloc_slot   = w_sel_head - CONVEYOR_ADDR_WIDTH'(1);
    assign head         = w_sel_head;

    always_comb begin
        w_fwd_hit   = 1'b0;
        w_fwd_fault = F_NONE_W;
        w_fwd_value = '0;
        for (int p = WRITE_PORTS - 1; p >= 0; p--) begin
            if (wr_valid[p] && (wr_ctx[p] == ctx) && (wr_slot[p] == w_sel_rd_slot)) begin
                w_fwd_hit   = 1'b1;
                w_fwd_fault = wr_fault[p];
                w_fwd_value = wr_value[p];
            end
        end
    end

    // Forwarding only applies to an unfinished slot, matching what the slot will hold next cycle.
    always_comb begin
        halt         = 1'b0;
        fault        = F_NONE_W;
        access_value = '0;
        if (access_valid) begin
            if (w_sel_rd_finished) begin
                fault        = w_sel_rd_fault;
                access_value = w_sel_rd_value;
            end else if (w_fwd_hit) begin
                fault        = w_fwd_fault;
                access_value = w_fwd_value;
            end else begin
                halt = 1'b1;
            end
        end
    end

endmodule
